// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified byte-wide RAM arbiter.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int RAM_ADDR_W = 17;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [RAM_ADDR_W-1:0] ZeroRamAddr = '0;
  localparam logic [WORD_W-1:0]     ZeroWord    = '0;

  // Instruction fetches are always a full word.
  localparam logic [2:0] FETCH_LEN = 3'd4;

  // Byte count for a load/store size code; the reserved code 11 behaves as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_to_len = 3'd1;
      MEM_SIZE_H: size_to_len = 3'd2;
      MEM_SIZE_W: size_to_len = 3'd4;
      default:    size_to_len = 3'd4;
    endcase
  endfunction

  // Little-endian byte lane idx of a word.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
    word_byte = w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Collects single RAM bytes into a little-endian word, cleared when a new access starts.
// Latency: o_word_nxt is combinational from the current capture; the held word updates on the next edge.
// Backpressure: none; captures whenever i_cap_vld is high.
module mem_byte_assembler
  import mem_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cap_vld,
  input  logic [1:0]        i_idx,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word_nxt
);

  logic [WORD_W-1:0] r_word;

  // Next word: zeroed on start so unused upper bytes of short loads read as 0, else merge the captured byte.
  always_comb begin
    o_word_nxt = r_word;
    if (i_start) begin
      o_word_nxt = ZeroWord;
    end else if (i_cap_vld) begin
      o_word_nxt[{i_idx, 3'b000} +: 8] = i_byte;
    end
  end

  // Hold the partially assembled word between RAM cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= ZeroWord;
    end else begin
      r_word <= o_word_nxt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto one byte-wide RAM port (MEM > IF), splitting 1/2/4-byte accesses into byte cycles.
// Latency (accept edge to done, inclusive): read len+2 cycles, store len+1 cycles.
// Backpressure: requesters hold req until their done pulse; pc_changed aborts an in-flight fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_pc_changed,
  output logic [DATA_W-1:0] o_if_data,
  output logic              o_if_done,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [1:0]        i_mem_size,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_done,
  input  logic [7:0]        i_ram_din,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_dout,
  output logic              o_ram_wr
);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_len;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_wdata;

  logic              w_start;
  logic              w_cap_vld;
  logic [1:0]        w_cap_idx;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_more;
  logic [DATA_W-1:0] w_word_nxt;

  // Accept/capture decode shared by the FSM and the byte assembler.
  always_comb begin
    w_start    = (r_state == S_IDLE) && (i_mem_req || (i_if_req && !i_pc_changed));
    w_cap_vld  = ((r_state == S_FETCH) || (r_state == S_LOAD)) && (r_cnt != 3'd0);
    w_cap_idx  = 2'(r_cnt - 3'd1);
    w_addr_nxt = r_base + ADDR_W'(r_cnt + 3'd1);
    w_more     = (r_cnt + 3'd1) < r_len;
  end

  // ram_din lags ram_addr by one cycle, so byte cnt-1 arrives while the counter reads cnt.
  mem_byte_assembler u_asm (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_cap_vld  (w_cap_vld),
    .i_idx      (w_cap_idx),
    .i_byte     (i_ram_din),
    .o_word_nxt (w_word_nxt)
  );

  // Sequencer: the RAM address/strobe for byte 0 is registered on the accept edge so data returns without a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_len       <= 3'd0;
      r_base      <= ZeroRamAddr;
      r_wdata     <= ZeroWord;
      o_if_data   <= ZeroWord;
      o_if_done   <= 1'b0;
      o_mem_rdata <= ZeroWord;
      o_mem_done  <= 1'b0;
      o_ram_addr  <= ZeroRamAddr;
      o_ram_dout  <= 8'h00;
      o_ram_wr    <= 1'b0;
    end else begin
      o_if_done  <= 1'b0;
      o_mem_done <= 1'b0;
      o_ram_wr   <= 1'b0;
      o_ram_dout <= 8'h00;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (i_mem_req) begin
            r_base     <= i_mem_addr;
            r_len      <= size_to_len(i_mem_size);
            r_wdata    <= i_mem_wdata;
            o_ram_addr <= i_mem_addr;
            if (i_mem_we) begin
              r_state    <= S_STORE;
              o_ram_wr   <= 1'b1;
              o_ram_dout <= word_byte(i_mem_wdata, 2'd0);
            end else begin
              r_state <= S_LOAD;
            end
          end else if (i_if_req && !i_pc_changed) begin
            r_state    <= S_FETCH;
            r_base     <= i_if_addr;
            r_len      <= FETCH_LEN;
            o_ram_addr <= i_if_addr;
          end
        end
        S_FETCH, S_LOAD: begin
          if ((r_state == S_FETCH) && i_pc_changed) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else if (r_cnt == r_len) begin
            r_state <= S_RESP;
            r_cnt   <= 3'd0;
            if (r_state == S_FETCH) begin
              o_if_done <= 1'b1;
              o_if_data <= w_word_nxt;
            end else begin
              o_mem_done  <= 1'b1;
              o_mem_rdata <= w_word_nxt;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (w_more) begin
              o_ram_addr <= w_addr_nxt;
            end
          end
        end
        S_STORE: begin
          if (w_more) begin
            r_cnt      <= r_cnt + 3'd1;
            o_ram_addr <= w_addr_nxt;
            o_ram_dout <= word_byte(r_wdata, r_cnt[1:0] + 2'd1);
            o_ram_wr   <= 1'b1;
          end else begin
            r_state    <= S_RESP;
            r_cnt      <= 3'd0;
            o_mem_done <= 1'b1;
          end
        end
        S_RESP: begin
          // The done pulse is already on the outputs this cycle; a redirect here just
          // returns to IDLE like any other completion and the IF stage discards the word.
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
